truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 107 ++++++++++
 tb/tb_truth_table_sweeper.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a small combinational gate, waits SETTLE cycles per
// vector, samples the gate output and compares the observed truth table to EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned             N_IN     = 2,
  parameter int unsigned             SETTLE   = 2,
  parameter logic [2**N_IN-1:0]      EXPECTED = 4'b0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      gate_in,
  input  logic                 gate_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        err_count,
  output logic                 match
);

  localparam int unsigned       ROWS        = 2**N_IN;
  localparam logic [N_IN-1:0]   VEC_LAST    = '1;
  localparam logic [N_IN-1:0]   VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]     ERR_ONE     = (N_IN + 1)'(1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [3:0]        settle_q, settle_d;
  logic [ROWS-1:0]   table_q, table_d;
  logic [N_IN:0]     err_q, err_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      table_q  <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    table_d  = table_q;
    err_d    = err_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          table_d  = '0;
          err_d    = '0;
          valid_d  = 1'b0;
          vec_d    = '0;
          settle_d = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[vec_q] = gate_out;
        if (gate_out != EXPECTED[vec_q]) err_d = err_q + ERR_ONE;
        // vec holds at the last row so gate_in stays put through FINISH
        if (vec_q == VEC_LAST) begin
          state_d = FINISH;
        end else begin
          vec_d    = vec_q + VEC_ONE;
          settle_d = '0;
          state_d  = WAIT;
        end
      end
      FINISH: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gate_in   = vec_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign table_out = table_q;
  assign err_count = err_q;
  assign match     = valid_q && (err_q == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: cycle-count reference model for the default build,
// directed checks for a 3-input build.
module tb_truth_table_sweeper;

  localparam int          S  = 2;
  localparam int          V  = 4;
  localparam int          L  = V * (S + 1) + 1;
  localparam logic [3:0]  E  = 4'b0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       gate_out = 1'b0;
  logic [1:0] gate_in;
  logic       busy, done, match;
  logic [3:0] table_out;
  logic [2:0] err_count;

  logic       start_b = 1'b0;
  logic [2:0] gate_in_b;
  logic       gate_out_b;
  logic       busy_b, done_b, match_b;
  logic [7:0] table_b;
  logic [3:0] err_b;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(2), .SETTLE(2), .EXPECTED(4'b0100)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_in(gate_in), .gate_out(gate_out),
    .busy(busy), .done(done), .table_out(table_out), .err_count(err_count), .match(match)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h80)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .gate_in(gate_in_b), .gate_out(gate_out_b),
    .busy(busy_b), .done(done_b), .table_out(table_b), .err_count(err_b), .match(match_b)
  );

  assign gate_out_b = &gate_in_b;

  // gate under test for the default build: row-2 detector, AND, or random noise
  always @(negedge clk) begin
    case (mode)
      0:       gate_out <= (gate_in == 2'd2);
      1:       gate_out <= &gate_in;
      default: gate_out <= 1'($urandom);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a sweep is c = 1..L cycles after acceptance; row r is held for S+1 cycles,
  // sampled on its last one, and cycle L is the done cycle
  bit         m_active;
  int         m_c;
  logic [3:0] m_table;
  int         m_err;
  bit         m_valid;
  int         m_vec_idle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active   <= 1'b0;
      m_c        <= 0;
      m_table    <= '0;
      m_err      <= 0;
      m_valid    <= 1'b0;
      m_vec_idle <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_c      <= 1;
        m_table  <= '0;
        m_err    <= 0;
        m_valid  <= 1'b0;
      end
    end else begin
      if (m_c < L && m_c % (S + 1) == 0) begin
        m_table[(m_c - 1) / (S + 1)] <= gate_out;
        if (gate_out !== E[(m_c - 1) / (S + 1)]) m_err <= m_err + 1;
      end
      if (m_c == L) begin
        m_active   <= 1'b0;
        m_valid    <= 1'b1;
        m_vec_idle <= V - 1;
      end else begin
        m_c <= m_c + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int exp_gi;
      if (!m_active)     exp_gi = m_vec_idle;
      else if (m_c < L)  exp_gi = (m_c - 1) / (S + 1);
      else               exp_gi = V - 1;
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_active && m_c == L));
      chk("gate_in", 32'(gate_in), 32'(exp_gi));
      chk("table_out", 32'(table_out), 32'(m_table));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("match", 32'(match), 32'(!m_active && m_valid && m_err == 0));
    end
  end

  logic [1:0] gi_log [1:12];

  task automatic sweep_a(input int hold, input int watch, output int first_done, output int n_done);
    @(negedge clk);
    start = 1'b1;
    first_done = -1;
    n_done = 0;
    for (int c = 1; c <= watch; c++) begin
      @(negedge clk);
      if (c == hold) start = 1'b0;
      if (c <= 12) gi_log[c] = gate_in;
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] gi_exp [1:12];
    int fd, nd;
    gi_exp = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_table", 32'(table_out), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // row-2 gate matches the golden table
    mode = 0;
    sweep_a(1, 14, fd, nd);
    for (int i = 1; i <= 12; i++) chk($sformatf("gi_seq[%0d]", i), 32'(gi_log[i]), 32'(gi_exp[i]));
    chk("done_cycle", 32'(fd), 32'd13);
    chk("done_count", 32'(nd), 32'd1);
    chk("table_row2", 32'(table_out), 32'h4);
    chk("err_row2", 32'(err_count), 32'd0);
    chk("match_row2", 32'(match), 32'd1);

    // AND gate: rows 2 and 3 disagree
    mode = 1;
    sweep_a(1, 14, fd, nd);
    chk("done_cycle_and", 32'(fd), 32'd13);
    chk("table_and", 32'(table_out), 32'h8);
    chk("err_and", 32'(err_count), 32'd2);
    chk("match_and", 32'(match), 32'd0);

    // start held high: one done by cycle 20, second sweep already running
    mode = 0;
    sweep_a(20, 20, fd, nd);
    chk("hold_first_done", 32'(fd), 32'd13);
    chk("hold_done_count", 32'(nd), 32'd1);
    chk("hold_rebusy", 32'(busy), 32'd1);
    wait_idle();

    // reset in WAIT of row 2
    sweep_a(1, 7, fd, nd);
    chk("pre_rst_gi", 32'(gate_in), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_gi", 32'(gate_in), 32'd0);
    chk("arst_table", 32'(table_out), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    chk("arst_match", 32'(match), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep_a(1, 14, fd, nd);
    chk("post_rst_done", 32'(fd), 32'd13);
    chk("post_rst_table", 32'(table_out), 32'h4);
    chk("post_rst_match", 32'(match), 32'd1);

    // noisy gate output and random start traffic against the model
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    wait_idle();

    // 3-input AND, SETTLE=1
    @(negedge clk);
    start_b = 1'b1;
    fd = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_b = 1'b0;
        chk("b_busy", 32'(busy_b), 32'd1);
      end
      if (done_b === 1'b1 && fd < 0) fd = c;
    end
    chk("b_done_cycle", 32'(fd), 32'd17);
    chk("b_table", 32'(table_b), 32'h80);
    chk("b_err", 32'(err_b), 32'd0);
    chk("b_match", 32'(match_b), 32'd1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
